// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared types and constants for the fetch-side PC sequencer.
//   pc_seq_state_e : sequencer mode (RUN / DRAIN / HALTED)
//   PC_INCR        : sequential fetch stride in bytes
//   XLEN           : address width
// ---------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int          XLEN    = 32;
    localparam logic [31:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pc_seq_state_e;

endpackage

// File: rtl/pc_sequencer_halt_drain_fsm.sv
// ---------------------------------------------------------------------------
// halt_drain_fsm
// Owns the sequencer mode, the drain counter and the registered halt flag.
// A halt seen in RUN waits DRAIN_CYCLES edges so that older instructions in
// MEM/WB retire, then enters HALTED. A resume pulse in HALTED returns to RUN.
//
// Ports:
//   clk_i           in   core clock
//   rst_ni          in   asynchronous active-low reset
//   halt_detected_i in   valid halt instruction in EX
//   resume_i        in   debug resume pulse (honoured only in HALTED)
//   state_o         out  current mode, encoded as pc_seq_state_e
//   halted_o        out  registered "fully drained and stopped"
// ---------------------------------------------------------------------------
module halt_drain_fsm
    import pc_seq_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       halt_detected_i,
    input  logic       resume_i,
    output logic [1:0] state_o,
    output logic       halted_o
);

    // Counter only needs to hold DRAIN_CYCLES; keep at least one bit so the
    // DRAIN_CYCLES=0 build still elaborates cleanly.
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

    pc_seq_state_e    r_state;
    pc_seq_state_e    w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_halted;
    logic             w_halted_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_halted <= w_halted_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_halted_next = r_halted;
        case (r_state)
            RUN: begin
                if (halt_detected_i) begin
                    if (DRAIN_CYCLES == 0) begin
                        w_state_next  = HALTED;
                        w_halted_next = 1'b1;
                    end else begin
                        w_state_next = DRAIN;
                        w_cnt_next   = CNT_W'(DRAIN_CYCLES);
                    end
                end
            end
            DRAIN: begin
                // The edge that sees a count of 1 is the last drain edge.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_next  = HALTED;
                    w_cnt_next    = '0;
                    w_halted_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            HALTED: begin
                if (resume_i) begin
                    w_state_next  = RUN;
                    w_halted_next = 1'b0;
                end
            end
            default: begin
                w_state_next  = RUN;
                w_cnt_next    = '0;
                w_halted_next = 1'b0;
            end
        endcase
    end

    assign state_o  = r_state;
    assign halted_o = r_halted;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Fetch-side consumer of the EX-stage flow-change interface. Owns the fetch
// PC, applies redirects, generates IF/ID and ID/EX flushes, drains the pipe
// on halt and restarts fetch on a debug resume.
//
// Optional build macro: PC_SEQ_REDIRECT_COUNT_EN adds redirect_count_o, a
// saturating count of redirects accepted in RUN.
//
// Ports:
//   clk_i, rst_ni       clock / asynchronous active-low reset
//   stall_i             load-use stall, holds PC
//   pc_src_optn_i       redirect PC to target_addr_i
//   redirect_req_i      taken branch/jump in EX, flush younger stages
//   target_addr_i[31:0] redirect target
//   halt_detected_i     valid halt in EX
//   resume_i            debug resume pulse
//   resume_pc_i[31:0]   restart address
//   pc_o[31:0]          registered fetch address
//   fetch_en_o          instruction memory read enable
//   flush_if_id_o       clear IF/ID
//   flush_id_ex_o       clear ID/EX
//   halted_o            registered halted flag
//   misaligned_o        registered one-cycle pulse for misaligned redirect
//   redirect_count_o    (macro only) saturating redirect counter
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            pc_src_optn_i,
    input  logic            redirect_req_i,
    input  logic [XLEN-1:0] target_addr_i,
    input  logic            halt_detected_i,
    input  logic            resume_i,
    input  logic [XLEN-1:0] resume_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic            fetch_en_o,
    output logic            flush_if_id_o,
    output logic            flush_id_ex_o,
    output logic            halted_o,
    output logic            misaligned_o
`ifdef PC_SEQ_REDIRECT_COUNT_EN
    ,
    output logic [XLEN-1:0] redirect_count_o
`endif
);

    logic [1:0]      w_state_raw;
    pc_seq_state_e   w_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            r_misaligned;
    logic            w_misaligned_next;
    logic            w_redirect_take;
    logic            w_flush;
    logic            w_unused;

    // Restart addresses are forced word aligned, so the low bits never matter.
    assign w_unused = &{1'b0, resume_pc_i[1:0]};

    halt_drain_fsm #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_halt_drain_fsm (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .halt_detected_i (halt_detected_i),
        .resume_i        (resume_i),
        .state_o         (w_state_raw),
        .halted_o        (halted_o)
    );

    assign w_state = pc_seq_state_e'(w_state_raw);

    // Halt outranks a redirect in the same cycle; redirect outranks stall
    // because the stalled instruction is younger and is being flushed.
    assign w_redirect_take = (w_state == RUN) && pc_src_optn_i && !halt_detected_i;

    always_comb begin
        w_pc_next         = r_pc;
        w_misaligned_next = 1'b0;
        case (w_state)
            RUN: begin
                if (halt_detected_i) begin
                    w_pc_next = r_pc;
                end else if (pc_src_optn_i) begin
                    w_pc_next         = {target_addr_i[XLEN-1:2], 2'b00};
                    w_misaligned_next = |target_addr_i[1:0];
                end else if (stall_i) begin
                    w_pc_next = r_pc;
                end else begin
                    w_pc_next = r_pc + PC_INCR;
                end
            end
            HALTED: begin
                if (resume_i) begin
                    w_pc_next = {resume_pc_i[XLEN-1:2], 2'b00};
                end
            end
            default: begin
                w_pc_next = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc         <= RESET_PC;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_pc_next;
            r_misaligned <= w_misaligned_next;
        end
    end

    // Strobes are gated by reset so nothing fetches or flushes while held.
    always_comb begin
        fetch_en_o = 1'b0;
        w_flush    = 1'b0;
        if (rst_ni) begin
            if (w_state == RUN) begin
                fetch_en_o = !stall_i && !halt_detected_i;
                w_flush    = redirect_req_i || halt_detected_i;
            end else begin
                fetch_en_o = 1'b0;
                w_flush    = 1'b1;
            end
        end
    end

    assign flush_if_id_o = w_flush;
    assign flush_id_ex_o = w_flush;
    assign pc_o          = r_pc;
    assign misaligned_o  = r_misaligned;

`ifdef PC_SEQ_REDIRECT_COUNT_EN
    logic [XLEN-1:0] r_redirect_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_redirect_count <= '0;
        end else if (w_redirect_take && (r_redirect_count != {XLEN{1'b1}})) begin
            r_redirect_count <= r_redirect_count + 1'b1;
        end
    end

    assign redirect_count_o = r_redirect_count;
`else
    logic w_unused_take;
    assign w_unused_take = w_redirect_take;
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-side consumer of the EX-stage flow-change interface (pc_src_optn, redirect request, final target, halt detected).
- Owns the architectural fetch PC and applies redirects.
- Generates IF/ID and ID/EX flush strobes.
- Runs a halt-drain state machine so older instructions retire before the core reports halted.
- Restarts fetch on a debug resume.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
DRAIN_CYCLES, 2, cycles waited after halt detection so MEM/WB contents retire (0 legal)

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
stall_i  input  1  load-use stall from hazard unit; hold PC
pc_src_optn_i  input  1  1 = redirect PC to target_addr_i (already gated against halt upstream)
redirect_req_i  input  1  taken branch/jump in EX; flush younger stages
target_addr_i  input  32  redirect target from EX
halt_detected_i  input  1  valid halt instruction in EX
resume_i  input  1  debug resume pulse
resume_pc_i  input  32  restart address supplied with resume_i
pc_o  output  32  current fetch address (registered)
fetch_en_o  output  1  instruction memory read enable
flush_if_id_o  output  1  clear IF/ID register
flush_id_ex_o  output  1  clear ID/EX register
halted_o  output  1  core fully drained and stopped (registered)
misaligned_o  output  1  one-cycle pulse: redirect target had target_addr_i[1:0] != 0 (registered)

Behaviour:
- Reset (async, rst_ni=0):
  - pc_o=RESET_PC, state=RUN, drain counter=0.
  - halted_o=0, misaligned_o=0.
  - fetch_en_o, flush_if_id_o and flush_id_ex_o forced 0 while rst_ni=0.
- States: RUN, DRAIN, HALTED.
- RUN, PC update priority, evaluated each rising edge:
  1. halt_detected_i: hold pc. Go to DRAIN and load the counter with DRAIN_CYCLES; if DRAIN_CYCLES=0, go straight to HALTED.
  2. pc_src_optn_i: pc <= {target_addr_i[31:2],2'b00}. misaligned_o <= |target_addr_i[1:0].
  3. stall_i: hold pc.
  4. Otherwise pc <= pc + 4. Wraps modulo 2^32: 32'hFFFF_FFFC -> 0.
- Redirect beats stall: the stalled instruction is younger and gets flushed.
- RUN, combinational outputs:
  - flush_if_id_o = flush_id_ex_o = redirect_req_i | halt_detected_i.
  - fetch_en_o = !stall_i & !halt_detected_i.
- DRAIN:
  - Counter decrements each cycle; on reaching 1, next state is HALTED.
  - pc held.
  - fetch_en_o=0, both flushes held 1.
  - redirect_req_i, pc_src_optn_i, stall_i and resume_i are ignored.
- HALTED:
  - halted_o=1, registered on entry.
  - fetch_en_o=0, flushes=1, pc held.
  - resume_i=1: pc <= resume_pc_i with low 2 bits cleared, state RUN, halted_o=0 on the same edge.
  - First fetch of resume_pc_i happens the cycle after resume.
- resume_i outside HALTED is ignored.
- misaligned_o stays high exactly one cycle per misaligned redirect.
- Reset asserted mid-DRAIN or mid-HALTED aborts immediately to the reset values.
- Halt latency: halt_detected_i high at edge N gives halted_o=1 after edge N+DRAIN_CYCLES, or after edge N when DRAIN_CYCLES=0.

Optional Feature:
Macro: PC_SEQ_REDIRECT_COUNT_EN
- Defined:
  - Adds output redirect_count_o [31:0].
  - Increments on each RUN-state edge with pc_src_optn_i=1 and halt_detected_i=0.
  - Saturates at 32'hFFFF_FFFF; resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pc_seq_pkg holds:
  - typedef enum logic [1:0] {RUN, DRAIN, HALTED} pc_seq_state_e
  - localparam PC_INCR = 32'd4
  - localparam XLEN = 32
- One sub-module, halt_drain_fsm, is natural. It owns the state register, the drain counter and halted_o. Its inputs are halt_detected_i and resume_i; it exports the state to the PC datapath.

Test Plan:
- Sequential fetch: reset release, no stimulus, 4 cycles -> pc_o 0,4,8,12,16; fetch_en_o=1; flushes 0.
- Redirect over stall:
  - Stimulus: pc=0x20, stall_i=1, pc_src_optn_i=1, redirect_req_i=1, target=0x100.
  - Required: flushes=1 that cycle; next pc_o=0x100; misaligned_o=0.
- Misaligned target: target=0x102 -> pc_o=0x100 next cycle; misaligned_o=1 for exactly one cycle.
- Halt drain:
  - Stimulus: DRAIN_CYCLES=2, halt_detected_i pulse at pc=0x40.
  - Required: pc_o stays 0x40; fetch_en_o=0 and flushes=1 throughout; halted_o=1 two edges later.
  - Also: a redirect injected during DRAIN is ignored.
- Resume: in HALTED, resume_i=1 with resume_pc_i=0x200 -> halted_o=0 and pc_o=0x200 next cycle; fetch_en_o=1; then 0x204.
- Reset mid-DRAIN: assert rst_ni=0 asynchronously between edges -> pc_o=RESET_PC immediately, halted_o=0, state RUN after release. Also run with DRAIN_CYCLES=0: halted_o=1 one edge after halt_detected_i.
